// File: rtl/demux_1to2_8bitsl1_pkg.sv
// Shared constants for the L1 receive-side byte un-striper.
//   state_e : FSM encoding (ST_EMPTY = no byte held, ST_HALF = lane-0 byte held)
//   LANES   : number of output lanes
//   GAP_W   : width of the idle-gap counter
package demux_1to2_8bitsl1_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  localparam int LANES = 2;
  localparam int GAP_W = 4;

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: WIDTH-bit data register with load enable and a valid
// pulse that is high only in the cycle after a load.
//   clk, reset_L : clock, async active-low clear
//   ld           : load d this edge (also raises v for one cycle)
//   d            : byte to present on this lane
//   q, v         : registered lane byte and its valid pulse
module demux_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q <= '0;
      v <= 1'b0;
    end else begin
      v <= ld;
      if (ld) q <= d;
    end
  end

endmodule

// File: rtl/demux_1to2_8bitsl1.sv
// Receive-side byte un-striper. Consecutive valid bytes are split
// alternately into lane 0 / lane 1 and presented together as a pair.
// A lane-0 byte left waiting for MAX_GAP idle cycles is flushed alone
// with an orphan pulse.
//   clk, reset_L         : clock, async active-low reset
//   data_in, valid_in    : striped byte stream
//   data_out0/valid_out0 : lane 0 byte and pulse
//   data_out1/valid_out1 : lane 1 byte and pulse
//   orphan               : lane 0 flushed without a partner
module demux_1to2_8bitsl1
  import demux_1to2_8bitsl1_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_GAP = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             orphan
);

  state_e             state;
  logic [WIDTH-1:0]   hold;
  logic [GAP_W-1:0]   gap;
  logic               pair_fire;
  logic               flush_fire;

  // Completion wins: a valid byte in HALF never lets the flush fire.
  assign pair_fire  = (state == ST_HALF) && valid_in;
  assign flush_fire = (state == ST_HALF) && !valid_in &&
                      (gap == GAP_W'(MAX_GAP - 1));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state  <= ST_EMPTY;
      hold   <= '0;
      gap    <= '0;
      orphan <= 1'b0;
    end else begin
      orphan <= flush_fire;
      case (state)
        ST_EMPTY: begin
          if (valid_in) begin
            hold  <= data_in;
            gap   <= '0;
            state <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (pair_fire || flush_fire) state <= ST_EMPTY;
          else                         gap   <= gap + GAP_W'(1);
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  logic [LANES-1:0][WIDTH-1:0] lane_d;
  logic [LANES-1:0][WIDTH-1:0] lane_q;
  logic [LANES-1:0]            lane_ld;
  logic [LANES-1:0]            lane_v;

  // Lane 0 always takes the held byte (pair or flush); lane 1 takes the
  // arriving partner only when the pair completes.
  assign lane_d[0]  = hold;
  assign lane_d[1]  = data_in;
  assign lane_ld[0] = pair_fire || flush_fire;
  assign lane_ld[1] = pair_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .ld      (lane_ld[g]),
      .d       (lane_d[g]),
      .q       (lane_q[g]),
      .v       (lane_v[g])
    );
  end

  assign data_out0  = lane_q[0];
  assign data_out1  = lane_q[1];
  assign valid_out0 = lane_v[0];
  assign valid_out1 = lane_v[1];

endmodule
